// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative divider.
// Mode encodings, FSM states and operand helpers.
package divider_pkg;

  typedef enum logic [1:0] {
    MODE_DIV  = 2'b00,
    MODE_DIVU = 2'b01,
    MODE_REM  = 2'b10,
    MODE_REMU = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    SPECIAL
  } state_e;

  localparam int DIV_STEPS = 32;
  localparam int DIV_LAT   = 34;

  // DIV and REM interpret operands as two's complement
  function automatic logic is_signed(logic [1:0] m);
    return !m[0];
  endfunction

  // magnitude of v when treated as signed, else v itself
  function automatic logic [31:0] mag(logic [31:0] v, logic s);
    return (s && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle of the divider.
// master = issuing pipeline, slave = divider.
interface divider_if #(
  parameter int TAG_W = 4
);
  logic             valid_i;
  logic             ready_o;
  logic [31:0]      op1;
  logic [31:0]      op2;
  logic [1:0]       mode;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             valid_o;
  logic [31:0]      result_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output valid_i, op1, op2, mode, tag_i, flush_i,
    input  ready_o, valid_o, result_o, tag_o
  );

  modport slave (
    input  valid_i, op1, op2, mode, tag_i, flush_i,
    output ready_o, valid_o, result_o, tag_o
  );
endinterface

// File: rtl/divider_div_step.sv
// One restoring radix-2 iteration on {rem, quo}.
// Shifts, trial-subtracts, and sets the quotient bit.
module div_step (
  input  logic [63:0] acc,
  input  logic [31:0] dvsr,
  output logic [63:0] nxt
);
  logic [32:0] part;
  logic [32:0] trial;

  // borrow in bit 32 means the trial did not fit: restore
  always_comb begin
    part  = acc[63:31];
    trial = part - {1'b0, dvsr};
    if (trial[32]) nxt = {acc[62:0], 1'b0};
    else           nxt = {trial[31:0], acc[30:0], 1'b1};
  end
endmodule

// File: rtl/divider.sv
// Multi-cycle 32-bit integer divider with tag and flush.
// FSM: IDLE -> CALC (32 steps) -> FIX, or IDLE -> SPECIAL.
module divider
  import divider_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input logic      clk,
  input logic      rst_n,
  divider_if.slave bus
);
  state_e           state;
  logic [4:0]       cnt;
  logic [63:0]      rq;
  logic [63:0]      rq_nxt;
  logic [31:0]      dvsr;
  logic             rem_q;
  logic             neg_q;
  logic             neg_r;
  logic [TAG_W-1:0] tag_q;

  logic        sgn;
  logic        div0;
  logic        ovf;
  logic        accept;
  logic [31:0] spec_res;
  logic [31:0] fix_res;

  assign bus.ready_o = (state == IDLE);
  assign accept = bus.valid_i && bus.ready_o
               && !bus.flush_i;

  div_step u_step (
    .acc  (rq),
    .dvsr (dvsr),
    .nxt  (rq_nxt)
  );

  // classify request and pick the short-path result
  always_comb begin
    sgn  = is_signed(bus.mode);
    div0 = (bus.op2 == 32'h0);
    ovf  = sgn && (bus.op1 == 32'h8000_0000)
        && (bus.op2 == 32'hFFFF_FFFF);
    spec_res = 32'h0;
    if (div0)
      spec_res = bus.mode[1] ? bus.op1 : 32'hFFFF_FFFF;
    else
      spec_res = bus.mode[1] ? 32'h0 : 32'h8000_0000;
  end

  // restore signs on the finished quotient/remainder
  always_comb begin
    fix_res = 32'h0;
    if (rem_q)
      fix_res = neg_r ? -rq[63:32] : rq[63:32];
    else
      fix_res = neg_q ? -rq[31:0] : rq[31:0];
  end

  // control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      rq           <= 64'h0;
      dvsr         <= 32'h0;
      rem_q        <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      tag_q        <= '0;
      bus.valid_o  <= 1'b0;
      bus.result_o <= 32'h0;
      bus.tag_o    <= '0;
    end else if (bus.flush_i) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      bus.valid_o <= 1'b0;
    end else begin
      bus.valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tag_q <= bus.tag_i;
            rem_q <= bus.mode[1];
            neg_q <= sgn && (bus.op1[31] ^ bus.op2[31]);
            neg_r <= sgn && bus.op1[31];
            dvsr  <= mag(bus.op2, sgn);
            cnt   <= 5'd0;
            if (div0 || ovf) begin
              rq    <= {32'h0, spec_res};
              state <= SPECIAL;
            end else begin
              rq    <= {32'h0, mag(bus.op1, sgn)};
              state <= CALC;
            end
          end
        end
        CALC: begin
          rq  <= rq_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_STEPS - 1))
            state <= FIX;
        end
        FIX: begin
          bus.result_o <= fix_res;
          bus.tag_o    <= tag_q;
          bus.valid_o  <= 1'b1;
          state        <= IDLE;
        end
        SPECIAL: begin
          bus.result_o <= rq[31:0];
          bus.tag_o    <= tag_q;
          bus.valid_o  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: random and directed requests.
// Latency counts edges from the accept edge inclusive.
module tb_divider;
  import divider_pkg::*;

  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  divider_if #(.TAG_W(TW)) bus();

  divider #(.TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   res;
    logic [TW-1:0] tag;
    int            acc;
    int            lat;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_special(logic [1:0] m,
                                    logic [31:0] a,
                                    logic [31:0] b);
    bit sg = (m == MODE_DIV) || (m == MODE_REM);
    return (b == 0) || (sg && a == 32'h8000_0000
                        && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] model(logic [1:0] m,
                                        logic [31:0] a,
                                        logic [31:0] b);
    bit sg = (m == MODE_DIV) || (m == MODE_REM);
    bit rm = (m == MODE_REM) || (m == MODE_REMU);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg && a == 32'h8000_0000
                 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (sg) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return rm ? r : q;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exv);
    end
  endtask

  // monitor: pop and compare on every result pulse
  always @(negedge clk) begin
    if (rst_n && bus.valid_o) begin
      last_out = cyc;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse at edge %0d expected none",
                 cyc);
      end else begin
        e = sbq.pop_front();
        chk("result", bus.result_o, e.res);
        chk("tag", 32'(bus.tag_o), 32'(e.tag));
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        chk("ready_at_valid", 32'(bus.ready_o), 32'd1);
      end
    end
  end

  task automatic issue(input logic [1:0] m,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [TW-1:0] t,
                       input bit expect_it,
                       output int acc);
    int n = 0;
    exp_t x;
    acc = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: ready_o got 0 expected 1");
      return;
    end
    bus.mode    = m;
    bus.op1     = a;
    bus.op2     = b;
    bus.tag_i   = t;
    bus.valid_i = 1'b1;
    acc = cyc + 1;
    if (expect_it) begin
      x.res = model(m, a, b);
      x.tag = t;
      x.acc = acc;
      x.lat = is_special(m, a, b) ? 2 : DIV_LAT;
      sbq.push_back(x);
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.op1     = $urandom;
    bus.op2     = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    int a1;
    int a2;
    int sel;
    logic [1:0] m;
    logic [31:0] x;
    logic [31:0] y;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op1     = 32'h0;
    bus.op2     = 32'h0;
    bus.mode    = 2'b00;
    bus.tag_i   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_tag", 32'(bus.tag_o), 32'd0);
    rst_n = 1'b1;

    issue(MODE_DIV, 32'd7, 32'd2, 4'd3, 1'b1, a1);
    drain();
    issue(MODE_REM, 32'hFFFF_FFF9, 32'd2, 4'd4, 1'b1, a1);
    issue(MODE_DIV, 32'hFFFF_FFF9, 32'd2, 4'd5, 1'b1, a1);
    drain();
    issue(MODE_DIVU, 32'h1234_5678, 32'd0, 4'd6, 1'b1, a1);
    issue(MODE_REMU, 32'h1234_5678, 32'd0, 4'd7, 1'b1, a1);
    issue(MODE_REM, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8,
          1'b1, a1);
    drain();

    issue(MODE_DIVU, 32'd100, 32'd7, 4'd1, 1'b1, a1);
    issue(MODE_REMU, 32'd100, 32'd7, 4'd2, 1'b1, a2);
    chk("b2b_accept", 32'(a2), 32'(last_out + 1));
    drain();

    issue(MODE_DIVU, 32'd100, 32'd7, 4'd5, 1'b0, a1);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_ready", 32'(bus.ready_o), 32'd1);
    chk("flush_valid", 32'(bus.valid_o), 32'd0);
    issue(MODE_DIVU, 32'd100, 32'd7, 4'd9, 1'b1, a1);
    drain();

    issue(MODE_DIVU, 32'd1000, 32'd3, 4'd6, 1'b0, a1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", bus.result_o, 32'h0);
    chk("mid_rst_tag", 32'(bus.tag_o), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      m   = 2'($urandom_range(0, 3));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) y = 32'h0;
      if (sel == 1) begin
        x = 32'h8000_0000;
        y = 32'hFFFF_FFFF;
      end
      if (sel == 2 || sel == 3) y = $urandom_range(1, 20);
      if (sel == 4) x = $urandom_range(0, 50);
      if (sel == 5) y = -$urandom_range(1, 9);
      issue(m, x, y, 4'($urandom_range(0, 15)), 1'b1, a1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter: TAG_W, default 4, width of the reservation-station/ROB tag carried through the unit.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  unit idle, can accept a request this cycle.
REQ-006 op1  input  32  dividend.
REQ-007 op2  input  32  divisor.
REQ-008 mode  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 tag_i  input  TAG_W  request tag.
REQ-010 flush_i  input  1  synchronous kill of in-flight operation (mispredict).
REQ-011 valid_o  output  1  result valid, one-cycle pulse.
REQ-012 result_o  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-013 tag_o  output  TAG_W  tag of the completing request.

Function
REQ-014 Accept occurs at a rising edge where valid_i && ready_o && !flush_i; op1, op2, mode, tag_i are captured then.
REQ-015 ready_o SHALL equal (state == IDLE); it is combinational from state only, never from valid_i.
REQ-016 States: IDLE, CALC, FIX, SPECIAL; IDLE->CALC on normal accept, IDLE->SPECIAL on special-case accept, CALC->FIX after 32 iterations, FIX->IDLE, SPECIAL->IDLE.
REQ-017 Signed modes (DIV, REM) convert operands to magnitudes at accept; unsigned modes use operands as-is.
REQ-018 CALC performs one restoring radix-2 step per cycle on a 64-bit {remainder, quotient} register with a 33-bit trial subtract; a 5-bit counter ends CALC after exactly 32 steps.
REQ-019 FIX applies signs: quotient negated iff signed mode and op1[31] != op2[31]; remainder negated iff signed mode and op1[31] set.
REQ-020 Normal latency: valid_o high in the cycle after the 34th rising edge following the accept edge (accept, 32 CALC, FIX registers output).
REQ-021 Divide-by-zero (op2 == 0): quotient 0xFFFFFFFF, remainder op1 unchanged, all modes; handled via SPECIAL.
REQ-022 Signed overflow (DIV/REM, op1 == 0x80000000, op2 == 0xFFFFFFFF): quotient 0x80000000, remainder 0; handled via SPECIAL.
REQ-023 SPECIAL latency: valid_o high in the cycle after the second rising edge following accept.
REQ-024 valid_o is a single-cycle pulse; result_o and tag_o hold their last value when valid_o is low.
REQ-025 In the valid_o cycle state is IDLE, ready_o is high, and a new request may be accepted (back-to-back).
REQ-026 flush_i high at an edge forces state to IDLE and valid_o low next cycle, regardless of state; flush_i has priority over acceptance and completion in that same edge.
REQ-027 No backpressure on the output; the consumer must sample valid_o when it pulses.

Reset
REQ-028 On rst_n low, immediately: state IDLE, counter 0, valid_o 0, result_o 0, tag_o 0, datapath registers 0; ready_o thus high.
REQ-029 Reset asserted mid-operation discards the operation; no valid_o pulse for it after release.

Structure
REQ-030 Shared package holds mode encodings (DIV, DIVU, REM, REMU), the state enumeration, and constants DIV_STEPS = 32 and DIV_LAT = 34.
REQ-031 One sub-module is natural: div_step, a combinational single restoring-division iteration (shift, trial subtract, quotient bit); the FSM and registers stay in divider.

Verification
REQ-032 DIV 7 / 2, tag 3 -> result_o 0x00000003, tag_o 3, valid_o exactly 34 edges after accept.
REQ-033 REM -7 (0xFFFFFFF9) / 2 -> result_o 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD.
REQ-034 DIVU 0x12345678 / 0 -> 0xFFFFFFFF and REMU same -> 0x12345678, each after 2 edges; REM 0x80000000 / 0xFFFFFFFF -> 0x00000000 after 2 edges.
REQ-035 Accept DIVU 100 / 7, assert flush_i 10 cycles later -> no valid_o ever for it, ready_o high the next cycle; following request completes correctly.
REQ-036 Second request presented during the valid_o cycle of the first -> accepted that edge; two pulses, tags in order, results 14 then 2 for DIVU 100/7 then REMU 100/7.
